// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG histogram monitor: sample width, quantised
// bin code table and the window state encoding.
package prng_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_BINS = 10;

  // Codes are k*2048/9 in Q5.11, truncated, for k = 0..9
  localparam logic [DATA_W-1:0] BIN_CODE [NUM_BINS] = '{
    16'h0000, 16'h00E3, 16'h01C7, 16'h02AA, 16'h038E,
    16'h0471, 16'h0555, 16'h0638, 16'h071C, 16'h0800
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/prng_histogram_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/prng_histogram_monitor.sv
// Windowed histogram of PRNG samples: exact-match binning into ten quantised
// codes plus an unmatched bin, with a total counter and registered readout.
module prng_histogram_monitor
  import prng_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  window_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_bin,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  total_count
);

  localparam int UNM_IDX = NUM_BINS;
  localparam int TOT_IDX = NUM_BINS + 1;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  logic [NUM_BINS-1:0] hit;
  logic                accept;
  logic                last_sample;
  logic [NUM_BINS+1:0] cnt_inc;
  logic [CNT_W-1:0]    cnt_q [NUM_BINS+2];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      hit[i] = (sample == BIN_CODE[i]);
    end
  end

  // start takes priority: a sample arriving with start is never counted
  assign accept      = (state_q == S_RUN) && sample_valid && !start;
  assign last_sample = accept && ((cnt_q[TOT_IDX] + CNT_W'(1)) == len_q);
  assign cnt_inc     = {accept, accept & ~(|hit), {NUM_BINS{accept}} & hit};

  for (genvar g = 0; g < NUM_BINS + 2; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .inc   (cnt_inc[g]),
      .q     (cnt_q[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_q      <= len_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (start) begin
      len_d   = window_len;
      state_d = (window_len == '0) ? S_DONE : S_RUN;
    end else if (last_sample) begin
      state_d = S_DONE;
    end
  end

  // Flags are derived from the next state so they change on the same edge as the FSM
  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    rd_count_d = cnt_q[UNM_IDX];
    for (int i = 0; i < NUM_BINS; i++) begin
      if (rd_bin == 4'(i)) begin
        rd_count_d = cnt_q[i];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_count    = rd_count_q;
  assign total_count = cnt_q[TOT_IDX];

endmodule

// File: tb/tb_prng_histogram_monitor.sv
// Randomised and directed bench for prng_histogram_monitor against a behavioural
// window/histogram model; a second instance covers a narrow counter width.
module tb_prng_histogram_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] window_len;
  logic        sample_valid;
  logic [15:0] sample;
  logic        busy;
  logic        done;
  logic [3:0]  rd_bin;
  logic [31:0] rd_count;
  logic [31:0] total_count;

  logic        start4;
  logic [3:0]  window_len4;
  logic        sample_valid4;
  logic [15:0] sample4;
  logic        busy4;
  logic        done4;
  logic [3:0]  rd_bin4;
  logic [3:0]  rd_count4;
  logic [3:0]  total_count4;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_cnt [11];
  logic [31:0] m_total;
  logic [31:0] m_len;
  logic        m_active;
  logic        m_done;

  always #5 clk = ~clk;

  prng_histogram_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .window_len   (window_len),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .done         (done),
    .rd_bin       (rd_bin),
    .rd_count     (rd_count),
    .total_count  (total_count)
  );

  prng_histogram_monitor #(
    .CNT_W (4)
  ) dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start4),
    .window_len   (window_len4),
    .sample_valid (sample_valid4),
    .sample       (sample4),
    .busy         (busy4),
    .done         (done4),
    .rd_bin       (rd_bin4),
    .rd_count     (rd_count4),
    .total_count  (total_count4)
  );

  function automatic int bin_of(input logic [15:0] s);
    for (int k = 0; k < 10; k++) begin
      if (s == 16'((k * 2048) / 9)) return k;
    end
    return 10;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] b);
    return (b >= 4'd10) ? m_cnt[10] : m_cnt[b];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 11; i++) m_cnt[i] = '0;
    m_total = '0;
  endtask

  task automatic model_step(input logic st, input logic [31:0] wl, input logic v, input logic [15:0] s);
    int idx;
    if (st) begin
      model_clear();
      m_len    = wl;
      m_active = (wl != 0);
      m_done   = (wl == 0);
    end else if (m_active && v) begin
      idx = bin_of(s);
      if (m_cnt[idx] != 32'hFFFF_FFFF) m_cnt[idx] = m_cnt[idx] + 1;
      if (m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
      if (m_total == m_len) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after the rising edge
  task automatic apply_stimulus(input logic st, input logic [31:0] wl, input logic v, input logic [15:0] s);
    logic [31:0] exp_rd;
    @(negedge clk);
    start        = st;
    window_len   = wl;
    sample_valid = v;
    sample       = s;
    exp_rd       = model_read(rd_bin);
    model_step(st, wl, v, s);
    @(posedge clk);
    #1;
    check_output("busy", {31'b0, busy}, {31'b0, m_active});
    check_output("done", {31'b0, done}, {31'b0, m_done});
    check_output("total_count", total_count, m_total);
    check_output("rd_count_live", rd_count, exp_rd);
  endtask

  task automatic read_bin(input logic [3:0] b);
    rd_bin = b;
    apply_stimulus(1'b0, 32'd0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    start         = 1'b0;
    sample_valid  = 1'b0;
    start4        = 1'b0;
    sample_valid4 = 1'b0;
    reset         = 1'b1;
    model_clear();
    m_len    = '0;
    m_active = 1'b0;
    m_done   = 1'b0;
    #2;
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_total", total_count, 32'd0);
    check_output("reset_rd_count", rd_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] sum;
    logic [15:0] s;
    int          k;
    int          guard;
    logic [15:0] t3 [4];

    window_len  = '0;
    sample      = '0;
    rd_bin      = '0;
    window_len4 = '0;
    sample4     = '0;
    rd_bin4     = '0;
    do_reset();

    // Test 1: five copies of bin 3's code
    apply_stimulus(1'b1, 32'd5, 1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'h02AA);
    check_output("t1_done", {31'b0, done}, 32'd1);
    for (int b = 0; b <= 10; b++) begin
      read_bin(4'(b));
      check_output("t1_bin", rd_count, (b == 3) ? 32'd5 : 32'd0);
    end
    check_output("t1_total", total_count, 32'd5);

    // Test 2: one of each code in order
    apply_stimulus(1'b1, 32'd10, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'((i * 2048) / 9));
    for (int b = 0; b <= 10; b++) begin
      read_bin(4'(b));
      check_output("t2_bin", rd_count, (b == 10) ? 32'd0 : 32'd1);
    end
    check_output("t2_total", total_count, 32'd10);

    // Test 3: near-miss values land in the unmatched bin
    t3 = '{16'h0001, 16'h0800, 16'h02AB, 16'h0800};
    apply_stimulus(1'b1, 32'd4, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 32'd0, 1'b1, t3[i]);
    read_bin(4'd9);
    check_output("t3_bin9", rd_count, 32'd2);
    read_bin(4'd10);
    check_output("t3_unmatched", rd_count, 32'd2);
    read_bin(4'd15);
    check_output("t3_unmatched_hi_sel", rd_count, 32'd2);

    // Test 4: valid gaps mid-window, live readout of bin 6 while running
    rd_bin = 4'd6;
    apply_stimulus(1'b1, 32'd6, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0555);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'd0, 1'b0, 16'h0555);
    check_output("t4_busy_gap", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0555);
    check_output("t4_done", {31'b0, done}, 32'd1);
    check_output("t4_total", total_count, 32'd6);

    // Test 5: zero-length window, then restart during RUN
    apply_stimulus(1'b1, 32'd0, 1'b1, 16'h0000);
    check_output("t5_zero_done", {31'b0, done}, 32'd1);
    check_output("t5_zero_busy", {31'b0, busy}, 32'd0);
    apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0000);
    check_output("t5_zero_total", total_count, 32'd0);
    apply_stimulus(1'b1, 32'd3, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0000);
    apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0000);
    apply_stimulus(1'b1, 32'd3, 1'b1, 16'h0000);
    check_output("t5_restart_total", total_count, 32'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'h0000);
    read_bin(4'd0);
    check_output("t5_restart_bin0", rd_count, 32'd3);

    // start coincident with the last sample of a window: the sample is dropped
    apply_stimulus(1'b1, 32'd2, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 32'd0, 1'b1, 16'h071C);
    apply_stimulus(1'b1, 32'd2, 1'b1, 16'h071C);
    check_output("coinc_busy", {31'b0, busy}, 32'd1);
    check_output("coinc_total", total_count, 32'd0);

    // Test 6: reset mid-window aborts with nothing retained
    apply_stimulus(1'b1, 32'd20, 1'b0, 16'h0000);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 32'd0, 1'b1, 16'h038E);
    @(posedge clk);
    #1;
    do_reset();
    for (int b = 0; b <= 10; b++) begin
      read_bin(4'(b));
      check_output("t6_reset_bin", rd_count, 32'd0);
    end

    // Randomised window of 32 samples mixing exact codes and arbitrary values
    apply_stimulus(1'b1, 32'd32, 1'b0, 16'h0000);
    guard = 0;
    while (!m_done && guard < 400) begin
      k = $urandom_range(0, 9);
      s = ($urandom_range(0, 1) != 0) ? 16'((k * 2048) / 9) : 16'($urandom);
      apply_stimulus(1'b0, 32'd0, ($urandom_range(0, 3) != 0), s);
      guard++;
    end
    check_output("rand_done", {31'b0, done}, 32'd1);
    check_output("rand_total", total_count, 32'd32);
    sum = '0;
    for (int b = 0; b <= 10; b++) begin
      read_bin(4'(b));
      sum = sum + rd_count;
    end
    check_output("rand_bin_sum", sum, 32'd32);

    // Narrow counters: window of 15 with 20 offered samples of one code
    do_reset();
    @(negedge clk);
    start4      = 1'b1;
    window_len4 = 4'd15;
    @(negedge clk);
    start4        = 1'b0;
    sample_valid4 = 1'b1;
    sample4       = 16'h0555;
    for (int i = 0; i < 20; i++) @(negedge clk);
    sample_valid4 = 1'b0;
    rd_bin4       = 4'd6;
    @(negedge clk);
    @(negedge clk);
    check_output("w4_bin6", {28'b0, rd_count4}, 32'd15);
    check_output("w4_total", {28'b0, total_count4}, 32'd15);
    check_output("w4_done", {31'b0, done4}, 32'd1);
    rd_bin4 = 4'd10;
    @(negedge clk);
    @(negedge clk);
    check_output("w4_unmatched", {28'b0, rd_count4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
